// File: rtl/dvsdclaa_seq_1v8.sv
// Multi-cycle NIBBLES*4-bit adder reusing one 4-bit carry-lookahead slice, LSB nibble first.
// Optional subtract mode enabled by defining CLA_SEQ_SUB_EN.
`timescale 1ns/1ps
module dvsdclaa_seq_1v8 #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);

    localparam int unsigned IW = $clog2(NIBBLES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state;
    logic [NIBBLES-1:0][3:0]   a_q;
    logic [NIBBLES-1:0][3:0]   b_q;
    logic [NIBBLES-1:0][3:0]   sum_q;
    logic                      c_q;
    logic [IW-1:0]             idx;
    logic                      in_ready_q;
    logic                      out_valid_q;

    logic [3:0] sa, sb, g, p, c, s;
    logic       co;

    // Single lookahead slice; carries are flattened generate/propagate terms.
    always_comb begin
        sa   = a_q[idx];
        sb   = b_q[idx];
        g    = sa & sb;
        p    = sa ^ sb;
        c[0] = c_q;
        c[1] = g[0] | (p[0] & c_q);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_q);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_q);
        s    = p ^ c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            c_q         <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
`ifdef CLA_SEQ_SUB_EN
                        b_q        <= sub ? ~b : b;
                        c_q        <= sub ? 1'b1 : cin;
`else
                        b_q        <= b;
                        c_q        <= cin;
`endif
                        idx        <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= s;
                    c_q        <= co;
                    if (idx == IW'(NIBBLES - 1)) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = c_q;

endmodule

// File: tb/tb_dvsdclaa_seq_1v8.sv
// Self-checking bench for dvsdclaa_seq_1v8: directed cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_dvsdclaa_seq_1v8;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;
`ifdef CLA_SEQ_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dvsdclaa_seq_1v8 #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {cout,sum} as plain wide arithmetic; subtraction is a + ~b + 1.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
        logic [W:0] r;
        if (HAS_SUB && sb)
            r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
        else
            r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        return r;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(in_ready), 32'd1);
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic collect(input string tag, input logic [W:0] exp);
        int n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(N));
        check({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb);
        issue(x, y, ci, sb);
        collect(tag, model(x, y, ci, sb));
        release_out();
    endtask

    initial begin
        logic [W:0]   exp_bp;
        logic [W:0]   exp_pend;
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        bit           seen;

        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0);
        op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op("add_ffff_ffff_c1", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

        // Backpressure with a competing request held on the input side.
        exp_bp   = model(16'hA5A5, 16'h1111, 1'b1, 1'b0);
        exp_pend = model(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        issue(16'hA5A5, 16'h1111, 1'b1, 1'b0);
        collect("bp", exp_bp);
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_sum", 32'(sum), 32'(exp_bp[W-1:0]));
            check("bp_hold_cout", 32'(cout), 32'(exp_bp[W]));
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        collect("bp_pending", exp_pend);
        release_out();

        // Reset during the second RUN cycle discards the operation.
        issue(16'h8888, 16'h8888, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_valid", 32'(seen), 32'd0);
        op("after_rst_1p1", 16'h0001, 16'h0001, 1'b0, 1'b0);

        if (HAS_SUB) begin
            op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
            op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1);
        end

        for (int i = 0; i < 24; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rs = HAS_SUB ? 1'($urandom) : 1'b0;
            issue(ra, rb, rc, rs);
            collect("rand", model(ra, rb, rc, rs));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_out();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dvsdclaa_seq_1v8.md
# dvsdclaa_seq_1v8

Multi-cycle wide-word adder sequencer that computes a NIBBLES×4-bit sum by time-multiplexing a single 4-bit carry-lookahead slice, least-significant nibble first, one nibble per clock. Carry is kept in a register between nibbles. Sits between a requester and a consumer with valid/ready handshakes on both sides, and lets the 1.8 V adder macro serve word widths above 4 bits without replicating the slice.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation (W = 4*NIBBLES); legal range 2..16
- clk  input  1  sole clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in to nibble 0
- sub  input  1  subtract request (present only with CLA_SEQ_SUB_EN)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  result word
- cout  output  1  carry out of the top nibble

## Operation
- Internal: one 4-bit carry-lookahead slice (S = A + B + Cin, Cout), operand registers a_q/b_q (W), result register sum_q (W), carry register c_q, nibble index idx (ceil(log2 NIBBLES) bits).
- States: IDLE, RUN, DONE (binary encoded; reset state IDLE).
- IDLE: in_ready=1. On in_valid: a_q<=a, b_q<=b, c_q<=cin, idx<=0, sum_q<=0 -> RUN.
- RUN: in_ready=0. Slice inputs = a_q[4*idx+:4], b_q[4*idx+:4], c_q. Each cycle: sum_q[4*idx+:4]<=S, c_q<=Cout, idx<=idx+1. When idx==NIBBLES-1 -> DONE (idx not wrapped further).
- DONE: out_valid=1, sum=sum_q, cout=c_q, both stable until handshake. On out_ready -> IDLE.
- sum and cout driven from registers only; never combinational from the slice.
- in_valid ignored outside IDLE; a/b/cin sampled only on the accepting edge.
- out_ready ignored outside DONE.
- Arithmetic: {cout,sum} == a + b + cin modulo 2^(W+1), identical to a W-bit ripple of the slice.

## Timing
- Reset (asynchronous assert, synchronous-edge release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, idx=0, c_q=0.
- Accept edge T (in_valid & in_ready). RUN occupies edges T+1..T+NIBBLES. out_valid rises after edge T+NIBBLES.
- Latency accept->out_valid: NIBBLES cycles. Minimum issue interval: NIBBLES+2 cycles (DONE handshake cycle, then one IDLE cycle).
- Backpressure: out_ready low holds DONE indefinitely, outputs unchanged, in_ready=0.
- Reset mid-RUN or mid-DONE: operation discarded, no out_valid pulse, outputs return to reset values immediately.
- in_valid high during RUN/DONE: not consumed, no state effect; requester must hold it until in_ready.

## Configuration
- Macro CLA_SEQ_SUB_EN.
- Defined: sub port exists. On accept with sub=1: b_q<=~b, c_q<=1 (cin ignored); result = a - b mod 2^W, cout=1 means no borrow (a>=b). sub=0 behaves as plain add.
- Undefined: sub port absent; operation is always a + b + cin.

## Test plan
- Reset then idle: rst pulse -> in_ready=1, out_valid=0, sum=0, cout=0.
- NIBBLES=4, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples all four nibbles); a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
- Backpressure: out_ready held low 5 cycles after out_valid -> sum/cout stable, in_ready=0, new in_valid not accepted; release -> IDLE next cycle, next op accepted.
- Reset asserted on second RUN cycle -> outputs to reset values same cycle, no out_valid; subsequent 0x0001+0x0001 -> 0x0002.
- With CLA_SEQ_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0; a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
